// File: rtl/block_tx_buffer.sv
// Sample FIFO feeding the block-transfer-to-host stage: buffers bytes, announces full blocks, streams them out.
// Optional partial-block flush after an idle timeout is enabled by defining TX_BUF_TIMEOUT_EN.
module block_tx_buffer #(
  parameter int unsigned DEPTH_LOG2     = 6,
  parameter int unsigned BLOCK_LEN      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  uc_clk,
  input  logic                  uc_reset,
  input  logic [7:0]            sample_data,
  input  logic                  sample_valid,
  output logic                  start_transfer,
  output logic [7:0]            uc_length,
  input  logic                  transfer_ready,
  input  logic                  transfer_busy,
  output logic [7:0]            transfer_to_host,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned FW    = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_BLOCK = FW'(BLOCK_LEN);
  localparam logic [7:0]    LEN_BLOCK  = 8'(BLOCK_LEN);

`ifdef SIM
  if (BLOCK_LEN == 0 || BLOCK_LEN > 255 || BLOCK_LEN > DEPTH) begin : g_bad_block_len
    $error("block_tx_buffer: BLOCK_LEN out of range");
  end
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      len_q, len_d;
  logic            start_q, start_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, wr_en, pop;

  assign full  = (fill_q == FILL_FULL);
  assign empty = (fill_q == '0);
  assign wr_en = sample_valid && !full;
  assign pop   = (state_q == ST_SEND) && transfer_ready && !empty;

  assign start_transfer   = start_q;
  assign uc_length        = len_q;
  assign fill_level       = fill_q;
  assign overflow         = ovf_q;
  assign transfer_to_host = mem_q[rd_ptr_q];

`ifdef TX_BUF_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_fire;

  // Counts consecutive quiet IDLE cycles holding a partial block
  always_comb begin
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if ((state_q == ST_IDLE) && !sample_valid && !empty && (fill_q < FILL_BLOCK)) begin
      tmo_d    = tmo_q + TW'(1);
      tmo_fire = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`endif

  // FIFO pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    if (overflow_clr)          ovf_d = 1'b0;
    if (sample_valid && full)  ovf_d = 1'b1;
  end

  // Block sequencing: detect, announce, stream, wait for host
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    start_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_q >= FILL_BLOCK) begin
          state_d    = ST_START;
          len_d      = LEN_BLOCK;
          byte_cnt_d = LEN_BLOCK;
          start_d    = 1'b1;
        end
`ifdef TX_BUF_TIMEOUT_EN
        else if (tmo_fire) begin
          state_d    = ST_START;
          len_d      = 8'(fill_q);
          byte_cnt_d = 8'(fill_q);
          start_d    = 1'b1;
        end
`endif
      end
      ST_START: state_d = ST_SEND;
      ST_SEND: begin
        if (pop) begin
          byte_cnt_d = byte_cnt_q - 8'd1;
          if (byte_cnt_q == 8'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!transfer_busy) begin
          state_d = ST_IDLE;
          len_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is cleared so the head byte reads 0 out of reset
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

endmodule
